// File: rtl/fifo_read_streamer.sv
// fifo_read_streamer: pulls words from a registered-read FIFO into a 2-entry skid buffer and streams them out in BURST-beat groups.
module fifo_read_streamer #(
  parameter int WL = 5,
  parameter int BURST = 4
) (
  input  logic          clk,
  input  logic          n_rst,
  input  logic          enable,
  input  logic          fifo_empty,
  input  logic [WL-1:0] fifo_data,
  output logic          fifo_read_rq,
  output logic          m_valid,
  output logic [WL-1:0] m_data,
  output logic          m_last,
  input  logic          m_ready,
  output logic          busy
);
  localparam int CW = (BURST > 1) ? $clog2(BURST) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t state;
  logic inflight, push, pop;
  logic [1:0] occ, occ_ap, occ_n;
  logic [WL-1:0] b0, b1;
  logic [CW-1:0] beat_cnt;
  always_comb begin
    push = inflight;
    pop = m_valid && m_ready;
    occ_ap = occ - 2'(pop);
    occ_n = occ_ap + 2'(push);
  end
  assign m_valid = occ != 2'd0;
  assign m_data = b0;
  assign m_last = m_valid && beat_cnt == CW'(BURST - 1);
  assign busy = state != IDLE;
  // Only one read outstanding; a new read is issued only when the buffer has room for its word.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state <= IDLE;
      fifo_read_rq <= 1'b0;
      inflight <= 1'b0;
      occ <= 2'd0;
      b0 <= '0;
      b1 <= '0;
      beat_cnt <= '0;
    end else begin
      state <= enable ? RUN : state == IDLE ? IDLE : state == RUN ? DRAIN :
               (occ == 2'd0 && !inflight) ? IDLE : DRAIN;
      fifo_read_rq <= state == RUN && enable && !fifo_empty && !fifo_read_rq &&
                      ({1'b0, occ_n} + 3'(fifo_read_rq)) < 3'd2;
      inflight <= fifo_read_rq;
      occ <= occ_n;
      if (push && occ_ap == 2'd0) b0 <= fifo_data;
      else if (pop) b0 <= b1;
      if (push && occ_ap == 2'd1) b1 <= fifo_data;
      if (pop) beat_cnt <= beat_cnt == CW'(BURST - 1) ? '0 : beat_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_fifo_read_streamer.sv
// tb_fifo_read_streamer: directed and random checks of fifo_read_streamer against a FIFO model and an in-order scoreboard.
module tb_fifo_read_streamer;
  logic clk = 1'b0;
  logic n_rst = 1'b1;
  logic enable = 1'b0;
  logic fifo_empty = 1'b1;
  logic [4:0] fifo_data = '0;
  logic fifo_read_rq, m_valid, m_last, busy;
  logic [4:0] m_data;
  logic m_ready = 1'b0;
  logic wr_en = 1'b0;
  logic [4:0] wr_data = '0;
  logic fifo_clr = 1'b0;
  logic rq_empty_err = 1'b0;
  int reads = 0;
  logic [4:0] fq[$];
  logic [4:0] exp_q[$];
  int tests = 0, fails = 0, beats = 0, delivered = 0;

  fifo_read_streamer #(.WL(5), .BURST(4)) dut (
    .clk(clk), .n_rst(n_rst), .enable(enable), .fifo_empty(fifo_empty),
    .fifo_data(fifo_data), .fifo_read_rq(fifo_read_rq), .m_valid(m_valid),
    .m_data(m_data), .m_last(m_last), .m_ready(m_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  // Upstream FIFO: registered read data, empty flag follows the word count.
  always @(posedge clk) begin
    if (fifo_clr) fq.delete();
    else begin
      if (fifo_read_rq) begin
        if (fifo_empty) rq_empty_err <= 1'b1;
        else begin
          fifo_data <= fq.pop_front();
          reads <= reads + 1;
        end
      end
      if (wr_en) fq.push_back(wr_data);
    end
    fifo_empty <= fq.size() == 0;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One cycle: drive inputs at the falling edge and score any beat the next rising edge accepts.
  task automatic step(input logic rdy, input logic we, input logic [4:0] wd);
    @(negedge clk);
    m_ready = rdy;
    wr_en = we;
    wr_data = wd;
    if (m_valid && rdy) begin
      chk("beat_data", {27'd0, m_data}, exp_q.size() != 0 ? {27'd0, exp_q[0]} : 32'hFFFF_FFFF);
      chk("beat_last", {31'd0, m_last}, {31'd0, beats % 4 == 3});
      if (exp_q.size() != 0) void'(exp_q.pop_front());
      beats++;
      delivered++;
    end
    if (we) exp_q.push_back(wd);
  endtask

  task automatic drain(input int budget, output int used);
    used = 0;
    while (exp_q.size() != 0 && used < budget) begin
      step(1'b1, 1'b0, 5'd0);
      used++;
    end
    chk("drain_done", exp_q.size(), 0);
  endtask

  initial begin
    int used, r0, d0, written;
    logic found;
    #2 n_rst = 1'b0;
    #1;
    chk("rst_rq", {31'd0, fifo_read_rq}, 0);
    chk("rst_valid", {31'd0, m_valid}, 0);
    chk("rst_data", {27'd0, m_data}, 0);
    chk("rst_last", {31'd0, m_last}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    step(1'b1, 1'b0, 5'd0);
    n_rst = 1'b1;
    // Burst of eight words, full-speed consumer
    for (int i = 1; i <= 8; i++) step(1'b1, 1'b1, 5'(i));
    step(1'b1, 1'b0, 5'd0);
    chk("idle_no_read", reads, 0);
    chk("idle_busy", {31'd0, busy}, 0);
    enable = 1'b1;
    step(1'b1, 1'b0, 5'd0);
    chk("first_edge_rq", {31'd0, fifo_read_rq}, 0);
    chk("run_busy", {31'd0, busy}, 1);
    step(1'b1, 1'b0, 5'd0);
    chk("second_edge_rq", {31'd0, fifo_read_rq}, 1);
    drain(40, used);
    chk("throughput", {31'd0, used <= 16}, 1);
    chk("burst_reads", reads, 8);
    // Single word
    r0 = reads;
    d0 = delivered;
    step(1'b1, 1'b1, 5'h1A);
    for (int i = 0; i < 12; i++) step(1'b1, 1'b0, 5'd0);
    chk("single_reads", reads - r0, 1);
    chk("single_beats", delivered - d0, 1);
    chk("single_idle_valid", {31'd0, m_valid}, 0);
    // Stalled consumer: buffer fills to two, then releases in order
    r0 = reads;
    for (int i = 1; i <= 8; i++) step(1'b0, 1'b1, 5'(i));
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 5'd0);
    chk("stall_reads", reads - r0, 2);
    chk("stall_valid", {31'd0, m_valid}, 1);
    chk("stall_data", {27'd0, m_data}, 1);
    drain(40, used);
    // Drain with a full buffer
    r0 = reads;
    d0 = delivered;
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 5'(5'h10 + i));
    for (int i = 0; i < 12; i++) step(1'b0, 1'b0, 5'd0);
    chk("pre_drain_reads", reads - r0, 2);
    enable = 1'b0;
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 5'd0);
    chk("drain_busy", {31'd0, busy}, 1);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 5'd0);
    chk("drain_beats", delivered - d0, 2);
    chk("drain_valid", {31'd0, m_valid}, 0);
    step(1'b1, 1'b0, 5'd0);
    chk("drain_idle_busy", {31'd0, busy}, 0);
    chk("drain_no_reads", reads - r0, 2);
    // Reset with one word held and one in flight
    enable = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      step(1'b0, 1'b0, 5'd0);
      found = fifo_read_rq && m_valid;
    end
    chk("mid_sync", {31'd0, found}, 1);
    step(1'b0, 1'b0, 5'd0);
    chk("mid_valid", {31'd0, m_valid}, 1);
    #2 n_rst = 1'b0;
    #1;
    chk("arst_rq", {31'd0, fifo_read_rq}, 0);
    chk("arst_valid", {31'd0, m_valid}, 0);
    chk("arst_data", {27'd0, m_data}, 0);
    chk("arst_last", {31'd0, m_last}, 0);
    chk("arst_busy", {31'd0, busy}, 0);
    exp_q.delete();
    beats = 0;
    fifo_clr = 1'b1;
    step(1'b1, 1'b0, 5'd0);
    fifo_clr = 1'b0;
    step(1'b1, 1'b0, 5'd0);
    n_rst = 1'b1;
    r0 = reads;
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 5'd0);
    chk("post_rst_reads", reads - r0, 0);
    chk("post_rst_valid", {31'd0, m_valid}, 0);
    d0 = delivered;
    step(1'b1, 1'b1, 5'h15);
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 5'd0);
    chk("post_rst_beat", delivered - d0, 1);
    // Random producer and consumer
    written = 0;
    for (int i = 0; i < 8000 && written < 1000; i++) begin
      logic we;
      we = 1'($urandom_range(0, 1));
      step($urandom_range(0, 3) != 0, we, 5'($urandom));
      if (we) written++;
    end
    chk("rand_written", written, 1000);
    drain(4000, used);
    chk("rq_while_empty", {31'd0, rq_empty_err}, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
